nukv_rotation_apply: RTL

- Sits directly downstream of the rotation-matrix buffer in the privacy pipeline.
- Captures each completed COL_COUNT x COL_COUNT rotation matrix from the buffer.
- Multiplies every incoming value row (COL_COUNT columns) by the active matrix to produce the rotation-perturbed row.
- Uses one signed fixed-point multiply-accumulate (MAC) per cycle, sequenced by an FSM, with valid/ready handshakes on both the row input and the row output.

---
 rtl/nukv_privacy_pkg.sv | 27 ++
 rtl/nukv_fxp_mac.sv | 46 ++++
 rtl/nukv_rotation_apply.sv | 131 +++++++++++++
 3 files changed

// File: rtl/nukv_privacy_pkg.sv
// Shared types and helpers for the privacy pipeline rotation stage.
// Holds the default geometry, FSM encoding, element offset and accumulator sizing.
package nukv_privacy_pkg;

  localparam int DEF_COL_COUNT = 3;
  localparam int DEF_COL_WIDTH = 64;
  localparam int DEF_FRAC_BITS = 32;

  typedef enum logic [1:0] {
    NO_MATRIX = 2'd0,
    IDLE      = 2'd1,
    MAC       = 2'd2,
    OUT       = 2'd3
  } rot_state_t;

  // Bit offset of matrix element (i,j) in the flattened matrix word.
  function automatic int elem_offset(input int i, input int j, input int col_count,
                                     input int col_width);
    return (i * col_count + j) * col_width;
  endfunction

  // Room for col_count full-width products plus a sign bit.
  function automatic int acc_width(input int col_width, input int col_count);
    return 2 * col_width + $clog2(col_count) + 1;
  endfunction

endpackage

// File: rtl/nukv_fxp_mac.sv
// Signed fixed-point MAC: registered accumulator with clear, combinational shift/saturate of acc+a*b.
// res reflects the sum including the current product; clr wins over en for the stored value.
module nukv_fxp_mac #(
  parameter int W     = 64,
  parameter int FRAC  = 32,
  parameter int ACC_W = 131
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] res
);

  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [2*W-1:0]   prod;

  // Arithmetic shift floors toward -inf; saturate when the kept bits are not a pure sign extension.
  function automatic logic signed [W-1:0] shift_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> FRAC;
    if ((&s[ACC_W-1:W-1]) || ~(|s[ACC_W-1:W-1])) return s[W-1:0];
    return s[ACC_W-1] ? MINV : MAXV;
  endfunction

  assign prod = a * b;
  assign sum  = acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
  assign res  = shift_sat(sum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/nukv_rotation_apply.sv
// Multiplies each value row by the newest applied rotation matrix, one MAC per cycle.
// Output transfers COL_COUNT^2+1 edges after accept; out_ready low holds the result and keeps row_ready low.
module nukv_rotation_apply
  import nukv_privacy_pkg::*;
#(
  parameter int COL_COUNT = DEF_COL_COUNT,
  parameter int COL_WIDTH = DEF_COL_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [COL_COUNT*COL_COUNT*COL_WIDTH-1:0] matrix_data,
  input  logic                                     matrix_valid,
  input  logic                                     matrix_last,
  input  logic [COL_COUNT*COL_WIDTH-1:0]           row_data,
  input  logic                                     row_valid,
  input  logic                                     row_last,
  output logic                                     row_ready,
  output logic [COL_COUNT*COL_WIDTH-1:0]           out_data,
  output logic                                     out_valid,
  output logic                                     out_last,
  input  logic                                     out_ready
);

  localparam int MW    = COL_COUNT * COL_COUNT * COL_WIDTH;
  localparam int RW    = COL_COUNT * COL_WIDTH;
  localparam int IW    = (COL_COUNT > 1) ? $clog2(COL_COUNT) : 1;
  localparam int ACC_W = acc_width(COL_WIDTH, COL_COUNT);
  localparam logic [IW-1:0] LAST = IW'(COL_COUNT - 1);

  rot_state_t state, state_d;
  logic [MW-1:0] pending_m, active_m;
  logic          pending_flag, have_matrix;
  logic [RW-1:0] row_q;
  logic [IW-1:0] i_q, j_q;
  logic          capture, apply, accept, mac_en, mac_clr;
  logic signed [COL_WIDTH-1:0] m_el, v_el, mac_res;

  assign capture   = matrix_valid && matrix_last;
  // Swapping matrices only between rows keeps every row on the matrix it started with.
  assign apply     = pending_flag && ((state == NO_MATRIX) || (state == IDLE));
  assign accept    = row_valid && row_ready;
  assign out_valid = (state == OUT);
  assign m_el      = active_m[elem_offset(int'(i_q), int'(j_q), COL_COUNT, COL_WIDTH) +: COL_WIDTH];
  assign v_el      = row_q[int'(j_q)*COL_WIDTH +: COL_WIDTH];

  nukv_fxp_mac #(.W(COL_WIDTH), .FRAC(FRAC_BITS), .ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (mac_en),
    .clr (mac_clr),
    .a   (m_el),
    .b   (v_el),
    .res (mac_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= NO_MATRIX;
    else      state <= state_d;
  end

  always_comb begin
    state_d   = state;
    row_ready = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    unique case (state)
      NO_MATRIX: if (apply) state_d = IDLE;
      IDLE: begin
        row_ready = have_matrix && !apply;
        if (row_valid && have_matrix && !apply) begin
          mac_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (j_q == LAST) begin
          mac_clr = 1'b1;
          if (i_q == LAST) state_d = OUT;
        end
      end
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = NO_MATRIX;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_m    <= '0;
      pending_flag <= 1'b0;
      active_m     <= '0;
      have_matrix  <= 1'b0;
    end else begin
      if (capture) begin
        pending_m    <= matrix_data;
        pending_flag <= 1'b1;
      end else if (apply) begin
        pending_flag <= 1'b0;
      end
      if (apply) begin
        active_m    <= pending_m;
        have_matrix <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q    <= '0;
      out_last <= 1'b0;
      out_data <= '0;
      i_q      <= '0;
      j_q      <= '0;
    end else if (accept) begin
      row_q    <= row_data;
      out_last <= row_last;
      i_q      <= '0;
      j_q      <= '0;
    end else if (state == MAC) begin
      if (j_q == LAST) begin
        out_data[int'(i_q)*COL_WIDTH +: COL_WIDTH] <= mac_res;
        j_q <= '0;
        i_q <= i_q + 1'b1;
      end else begin
        j_q <= j_q + 1'b1;
      end
    end
  end

endmodule
